// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch handshake: one outstanding request, completed by ready.
interface fetch_pc_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch/PC stage: owns the PC, issues imem requests, buffers one early response
// in a skid entry and squashes wrong-path fetches on trap, mret and branch.
//   state     | meaning
//   S_START   | first cycle after reset, no request
//   S_FETCH   | requesting at pc (unless the skid entry is full)
//   S_DISCARD | pre-redirect request still outstanding, its response is dropped
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_initiate_exception,
    input  logic [31:0]     i_csr_mtvec,
    input  logic            i_mret,
    input  logic [31:0]     i_csr_mepc,
    input  logic            i_branch_taken,
    input  logic [31:0]     i_branch_target,
    input  logic            i_stall,
    fetch_pc_unit_if.master imem,
    output logic [31:0]     o_fd_inst,
    output logic [31:0]     o_fd_pc,
    output logic            o_fd_bubble
);
    typedef enum logic [1:0] {S_START, S_FETCH, S_DISCARD} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_skid_valid;
    logic [31:0] r_fd_inst;
    logic [31:0] r_fd_pc;
    logic        r_fd_bubble;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_req;
    logic        w_accept;
    logic        w_discard_next;
    logic [31:0] w_pc_next;

    assign w_redirect = i_initiate_exception | i_mret | i_branch_taken;

    always_comb begin
        w_target = i_branch_target;
        if (i_initiate_exception)
            w_target = i_csr_mtvec;
        else if (i_mret)
            w_target = i_csr_mepc;
    end

    assign w_req    = (r_state == S_DISCARD) || ((r_state == S_FETCH) && !r_skid_valid);
    assign w_accept = (r_state == S_FETCH) && w_req && imem.ready && !w_redirect;

    // Only a request actually on the bus needs to be waited out; with the skid
    // full nothing is outstanding, so a redirect goes straight to the target.
    assign w_discard_next = w_req && !imem.ready && (w_redirect || (r_state == S_DISCARD));

    assign w_pc_next = w_redirect ? w_target : (w_accept ? r_pc + 32'd4 : r_pc);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_START;
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_skid_inst  <= NOP_INST;
            r_skid_pc    <= RESET_PC;
            r_skid_valid <= 1'b0;
            r_fd_inst    <= NOP_INST;
            r_fd_pc      <= RESET_PC;
            r_fd_bubble  <= 1'b1;
        end else begin
            r_state <= w_discard_next ? S_DISCARD : S_FETCH;
            r_pc    <= w_pc_next;
            r_addr  <= w_discard_next ? r_addr : w_pc_next;

            if (w_redirect) begin
                r_skid_valid <= 1'b0;
                r_fd_bubble  <= 1'b1;
                r_fd_inst    <= NOP_INST;
            end else if (!i_stall) begin
                if (r_skid_valid) begin
                    r_fd_inst    <= r_skid_inst;
                    r_fd_pc      <= r_skid_pc;
                    r_fd_bubble  <= 1'b0;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_fd_inst   <= imem.rdata;
                    r_fd_pc     <= r_pc;
                    r_fd_bubble <= 1'b0;
                end else begin
                    // nothing new for FD: bubble rather than re-issue the old one
                    r_fd_inst   <= NOP_INST;
                    r_fd_bubble <= 1'b1;
                end
            end else if (w_accept) begin
                r_skid_inst  <= imem.rdata;
                r_skid_pc    <= r_pc;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign imem.req    = w_req;
    assign imem.addr   = r_addr;
    assign o_fd_inst   = r_fd_inst;
    assign o_fd_pc     = r_fd_pc;
    assign o_fd_bubble = r_fd_bubble;
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch and program-counter stage of the two-stage RV32I pipeline, directly upstream of the FD stage. It also consumes the trap/return redirects produced by the CSR/exception-handling unit in XB. It owns the PC, drives a single-outstanding-request instruction-memory handshake and absorbs one early response in a one-entry skid buffer when FD stalls. It supplies FD with instruction, PC and a bubble flag, and squashes wrong-path fetches on exception, mret and taken-branch redirects.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, instruction presented to FD while bubbled (addi x0,x0,0)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- initiate_exception  in  1  trap from XB this cycle; redirect to csr_mtvec
- csr_mtvec  in  32  trap vector, bits[1:0] already zero
- mret  in  1  XB instruction is a committed MRET; redirect to csr_mepc
- csr_mepc  in  32  return address
- branch_taken  in  1  XB jump/taken branch
- branch_target  in  32  jump/branch destination
- stall  in  1  FD cannot accept a new instruction this cycle
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, stable while imem_req is high and imem_ready is low
- imem_ready  in  1  response valid this cycle; completes the request
- imem_rdata  in  32  instruction word, valid with imem_ready
- FD_inst  out  32  instruction to FD
- FD_pc  out  32  PC of FD_inst
- FD_bubble  out  1  FD_inst is not a real instruction

## Operation
- Redirect priority: initiate_exception > mret > branch_taken > sequential. `redirect` is the OR of the three. `target` is the selected address, passed unmodified; misalignment is detected in FD.
- States:
  - START: one cycle after reset release, imem_req=0.
  - FETCH: imem_req=1, imem_addr=pc.
  - DISCARD: old request still outstanding after a redirect. imem_req=1 at the old address; the response is dropped.
- Transitions:
  - START→FETCH unconditionally.
  - FETCH→DISCARD on redirect && !imem_ready.
  - DISCARD→FETCH on imem_ready.
  - All other cases stay in the current state.
- Accept in FETCH (imem_ready && !redirect):
  - If !stall and skid empty: FD_inst<=imem_rdata, FD_pc<=pc, FD_bubble<=0.
  - If stall: capture {rdata,pc} into skid, skid_valid<=1.
  - In both cases pc<=pc+4, wrapping modulo 2^32.
- Request gating: when skid_valid=1, imem_req=0 (no new request) until the skid drains.
- Skid drain: when !stall and skid_valid, FD loads from the skid, skid_valid<=0, FD_bubble<=0.
- Stall with nothing new: FD registers hold.
- Redirect, in any state and overriding stall:
  - pc<=target, skid_valid<=0, FD_bubble<=1, FD_inst<=NOP_INST.
  - If imem_ready arrives in the same cycle, the response is dropped and the next state is FETCH at target.
- Redirect while in DISCARD: pc<=target again (latest wins). The state stays DISCARD until imem_ready.
- No stage is ever filled from a response whose request predates the most recent redirect.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - FD_inst=NOP_INST, FD_pc=RESET_PC, FD_bubble=1
  - skid_valid=0, state=START
- imem_addr is registered (equals pc). imem_req is decoded from state and skid_valid. No combinational path from redirect inputs to imem_req or imem_addr.
- Latency: redirect at cycle N → imem_addr=target at N+1. With zero-wait memory, the target instruction is in FD at N+2.
- Sequential throughput with zero-wait memory (imem_ready same cycle as req): one instruction per cycle.
- Bubble after redirect: FD_bubble=1 from N+1 until the first accepted target response.
- Reset mid-request: the outstanding response is ignored, since state returns to START and imem_req is low.

## Test plan
- Reset release, zero-wait memory returning addr as data → imem_req rises at cycle 2. FD_pc sequence 0,4,8 with FD_bubble=0 and FD_inst equal to those addresses.
- stall=1 for 3 cycles while imem_ready=1 at pc=8 → skid captures 8, imem_req drops, FD holds pc=4. On release FD_pc=8 then 12, with no loss and no duplicate.
- initiate_exception=1 with csr_mtvec=0x4 while branch_taken=1 and mret=1 → imem_addr=0x4 next cycle, one FD bubble, then FD_pc=0x4.
- Memory with 3 wait states, branch_taken to 0x100 in the first wait cycle → imem_addr holds the old address until imem_ready. Old data is dropped, then imem_addr=0x100 and FD_pc=0x100.
- mret with csr_mepc=0xFFFF_FFFC → FD_pc=0xFFFF_FFFC, then 0x0 (wrap).
- Assert reset while a 3-wait request is outstanding → all outputs return to reset values immediately. The late imem_ready is ignored, and the first FD_pc is RESET_PC.
